controle_multiciclo: RTL and testbench

Multicycle control unit and datapath sequencer that sits directly upstream of the 4x8-bit register bank. It fetches 8-bit instructions, decodes them, and drives the bank's read addresses, write address, write data and EscReg. It performs the ALU operation, accesses data memory and updates the PC. The register bank's negedge read timing is built into the state sequence.

---
 rtl/controle_multiciclo_pkg.sv | 53 +++++
 rtl/controle_multiciclo_ula8.sv | 27 ++
 rtl/controle_multiciclo.sv | 167 ++++++++++++++++
 tb/tb_controle_multiciclo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states and ALU selects.
package pkg_controle;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_MOV = 4'h5;
   localparam logic [3:0] OP_LI  = 4'h6;
   localparam logic [3:0] OP_LW  = 4'h7;
   localparam logic [3:0] OP_SW  = 4'h8;
   localparam logic [3:0] OP_BEQ = 4'h9;
   localparam logic [3:0] OP_JMP = 4'hA;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      BUSCA     = 3'd0,
      DECOD     = 3'd1,
      BUSCA_IMM = 3'd2,
      EXEC      = 3'd3,
      MEM       = 3'd4,
      ESCR      = 3'd5,
      HALT      = 3'd6
   } estado_t;

   typedef enum logic [2:0] {
      ULA_ADD    = 3'd0,
      ULA_SUB    = 3'd1,
      ULA_AND    = 3'd2,
      ULA_OR     = 3'd3,
      ULA_PASS_B = 3'd4,
      ULA_EQ     = 3'd5
   } ula_op_t;

   // Opcode to ALU operation; loads/stores only need the ALU idle, PASS_B is harmless.
   function automatic ula_op_t ula_sel(input logic [3:0] op);
      case (op)
         OP_ADD:  return ULA_ADD;
         OP_SUB:  return ULA_SUB;
         OP_AND:  return ULA_AND;
         OP_OR:   return ULA_OR;
         OP_BEQ:  return ULA_EQ;
         default: return ULA_PASS_B;
      endcase
   endfunction

   // B..E are undefined and run as NOP.
   function automatic logic op_ilegal(input logic [3:0] op);
      return (op >= 4'hB) && (op <= 4'hE);
   endfunction

endpackage

// File: rtl/controle_multiciclo_ula8.sv
// Combinational ALU; EQ returns 1/0 in bit 0 for the branch compare.
module ula8
   import pkg_controle::*;
#(
   parameter int W = 8
) (
   input  ula_op_t      op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   // Select the operation; carry and borrow are discarded.
   always_comb begin
      y = '0;
      case (op)
         ULA_ADD:    y = a + b;
         ULA_SUB:    y = a - b;
         ULA_AND:    y = a & b;
         ULA_OR:     y = a | b;
         ULA_PASS_B: y = b;
         ULA_EQ:     y = (a == b) ? W'(1) : '0;
         default:    y = '0;
      endcase
   end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle sequencer driving the 4x8 register bank, instruction and data memories.
//
// state     | meaning
// BUSCA     | fetch opcode byte into IR, PC+1
// DECOD     | bank read addresses presented, bank updates read data on negedge
// BUSCA_IMM | fetch immediate byte, PC+1 (JMP loads PC here)
// EXEC      | ALU op, latch memory address/data, BEQ decision
// MEM       | data memory write (SW) or read (LW)
// ESCR      | single-cycle bank write
// HALT      | stopped until reset
module controle_multiciclo
   import pkg_controle::*;
#(
   parameter logic [7:0] PC_INICIAL = 8'h00,
   parameter int         LARGURA    = 8
) (
   input  logic               clk,
   input  logic               reset,
   output logic [LARGURA-1:0] imem_addr,
   input  logic [LARGURA-1:0] imem_data,
   output logic [LARGURA-1:0] dmem_addr,
   output logic [LARGURA-1:0] dmem_wdata,
   input  logic [LARGURA-1:0] dmem_rdata,
   output logic               EscMem,
   output logic [1:0]         read_addr1,
   output logic [1:0]         read_addr2,
   input  logic [LARGURA-1:0] read_data1,
   input  logic [LARGURA-1:0] read_data2,
   output logic [1:0]         write_addr,
   output logic [LARGURA-1:0] write_data,
   output logic               EscReg,
   output logic [2:0]         estado,
   output logic               parado,
   output logic               ilegal
);

   estado_t            estado_q, estado_d;
   logic [LARGURA-1:0] pc_q, pc_d;
   logic [LARGURA-1:0] ir_q, ir_d;
   logic [LARGURA-1:0] imm_q, imm_d;
   logic [LARGURA-1:0] result_q, result_d;
   logic [LARGURA-1:0] daddr_q, daddr_d;
   logic [LARGURA-1:0] dwdata_q, dwdata_d;
   logic [1:0]         ra1_q, ra1_d;
   logic [1:0]         ra2_q, ra2_d;
   logic [3:0]         op;
   ula_op_t            ula_op;
   logic [LARGURA-1:0] ula_y;

   assign op     = ir_q[7:4];
   assign ula_op = ula_sel(op);

   ula8 #(.W(LARGURA)) u_ula (
      .op (ula_op),
      .a  (read_data1),
      .b  (read_data2),
      .y  (ula_y)
   );

   // State and datapath latches; reset aborts any instruction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q <= BUSCA;
         pc_q     <= PC_INICIAL;
         ir_q     <= '0;
         imm_q    <= '0;
         result_q <= '0;
         daddr_q  <= '0;
         dwdata_q <= '0;
         ra1_q    <= '0;
         ra2_q    <= '0;
      end else begin
         estado_q <= estado_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         imm_q    <= imm_d;
         result_q <= result_d;
         daddr_q  <= daddr_d;
         dwdata_q <= dwdata_d;
         ra1_q    <= ra1_d;
         ra2_q    <= ra2_d;
      end
   end

   // Next-state and datapath updates per state.
   always_comb begin
      estado_d = estado_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      imm_d    = imm_q;
      result_d = result_q;
      daddr_d  = daddr_q;
      dwdata_d = dwdata_q;
      ra1_d    = ra1_q;
      ra2_d    = ra2_q;
      case (estado_q)
         BUSCA: begin
            ir_d     = imem_data;
            // Read addresses load with IR so they are stable for the whole DECOD cycle.
            ra1_d    = imem_data[3:2];
            ra2_d    = imem_data[1:0];
            pc_d     = pc_q + LARGURA'(1);
            estado_d = DECOD;
         end
         DECOD: begin
            case (op)
               OP_LI, OP_BEQ, OP_JMP:                 estado_d = BUSCA_IMM;
               OP_HLT:                                estado_d = HALT;
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV,
               OP_LW, OP_SW:                          estado_d = EXEC;
               default:                               estado_d = BUSCA;
            endcase
         end
         BUSCA_IMM: begin
            imm_d = imem_data;
            pc_d  = pc_q + LARGURA'(1);
            if (op == OP_JMP) begin
               pc_d     = imem_data;
               estado_d = BUSCA;
            end else if (op == OP_LI) begin
               estado_d = ESCR;
            end else begin
               estado_d = EXEC;
            end
         end
         EXEC: begin
            result_d = ula_y;
            daddr_d  = read_data2;
            dwdata_d = read_data1;
            if (op == OP_BEQ) begin
               if (ula_y[0]) pc_d = imm_q;
               estado_d = BUSCA;
            end else if (op == OP_LW || op == OP_SW) begin
               estado_d = MEM;
            end else begin
               estado_d = ESCR;
            end
         end
         MEM: begin
            if (op == OP_LW) begin
               result_d = dmem_rdata;
               estado_d = ESCR;
            end else begin
               estado_d = BUSCA;
            end
         end
         ESCR:    estado_d = BUSCA;
         HALT:    estado_d = HALT;
         default: estado_d = BUSCA;
      endcase
   end

   // Enables decode straight from the state register so reset kills them at once.
   assign imem_addr  = pc_q;
   assign dmem_addr  = daddr_q;
   assign dmem_wdata = dwdata_q;
   assign EscMem     = (estado_q == MEM) && (op == OP_SW);
   assign read_addr1 = ra1_q;
   assign read_addr2 = ra2_q;
   assign write_addr = ir_q[3:2];
   assign write_data = (op == OP_LI) ? imm_q : result_q;
   assign EscReg     = (estado_q == ESCR);
   assign estado     = estado_q;
   assign parado     = (estado_q == HALT);
   assign ilegal     = (estado_q == DECOD) && op_ilegal(op);

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: directed program, reset abort, then random programs
// checked per instruction against an instruction-level reference model.
module tb_controle_multiciclo;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] imem_addr, imem_data;
   logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic       EscMem;
   logic [1:0] read_addr1, read_addr2, write_addr;
   logic [7:0] read_data1, read_data2, write_data;
   logic       EscReg;
   logic [2:0] estado;
   logic       parado, ilegal;

   logic [7:0] imem [256];
   logic [7:0] dmem [256];
   logic [7:0] bank [4] = '{default: 8'h00};
   logic       fill_en = 1'b0;
   logic [7:0] fill_addr = 8'h00;
   logic [7:0] fill_val = 8'h00;

   int vectors = 0;
   int miscompares = 0;

   // instruction-level model state
   logic [7:0] m_pc;
   logic [7:0] m_r [4];
   logic [7:0] m_mem [256];

   controle_multiciclo #(.PC_INICIAL(8'h00), .LARGURA(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .EscMem     (EscMem),
      .read_addr1 (read_addr1),
      .read_addr2 (read_addr2),
      .read_data1 (read_data1),
      .read_data2 (read_data2),
      .write_addr (write_addr),
      .write_data (write_data),
      .EscReg     (EscReg),
      .estado     (estado),
      .parado     (parado),
      .ilegal     (ilegal)
   );

   always #5 clk = ~clk;

   assign imem_data  = imem[imem_addr];
   assign dmem_rdata = dmem[dmem_addr];

   // register bank: write on posedge, read ports refresh on negedge
   always @(posedge clk) if (EscReg) bank[write_addr] <= write_data;
   always @(negedge clk) begin
      read_data1 <= bank[read_addr1];
      read_data2 <= bank[read_addr2];
   end

   always @(posedge clk) begin
      if (EscMem) dmem[dmem_addr] <= dmem_wdata;
      else if (fill_en) dmem[fill_addr] <= fill_val;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one instruction starting from a sampled BUSCA; counts enables seen.
   task automatic exec_one(output int cyc, output int nesc, output int nmem, output int nill,
                           output int nbad, output logic [7:0] ma, output logic [7:0] md);
      cyc = 0; nesc = 0; nmem = 0; nill = 0; nbad = 0; ma = 8'h00; md = 8'h00;
      do begin
         if (EscReg) nesc++;
         if (EscMem) begin nmem++; ma = dmem_addr; md = dmem_wdata; end
         if (ilegal) nill++;
         if ((EscReg && estado != 3'd5) || (EscMem && estado != 3'd4)) nbad++;
         @(posedge clk); #1;
         cyc++;
      end while (estado != 3'd0 && cyc < 12);
   endtask

   logic [7:0] last_ma, last_md;

   task automatic instr(input string tag, input int ec, input int ee, input int em,
                        input int ei, input logic [7:0] epc);
      int c, e, m, il, b;
      exec_one(c, e, m, il, b, last_ma, last_md);
      chk({tag, "_cycles"}, c, ec);
      chk({tag, "_escreg"}, e, ee);
      chk({tag, "_escmem"}, m, em);
      chk({tag, "_ilegal"}, il, ei);
      chk({tag, "_stray_en"}, b, 0);
      chk({tag, "_pc"}, imem_addr, epc);
   endtask

   // Reference: architectural effect and cycle cost of one instruction.
   task automatic model_step(output int c, output int e, output int m, output int il);
      logic [7:0] ins, imm, pc1, a, b;
      logic [3:0] op;
      logic [1:0] rd, rs;
      ins = imem[m_pc];
      op  = ins[7:4]; rd = ins[3:2]; rs = ins[1:0];
      pc1 = m_pc + 8'd1;
      imm = imem[pc1];
      a = m_r[rd]; b = m_r[rs];
      c = 2; e = 0; m = 0; il = 0;
      m_pc = pc1;
      case (op)
         4'h0: ;
         4'h1: begin m_r[rd] = a + b; c = 4; e = 1; end
         4'h2: begin m_r[rd] = a - b; c = 4; e = 1; end
         4'h3: begin m_r[rd] = a & b; c = 4; e = 1; end
         4'h4: begin m_r[rd] = a | b; c = 4; e = 1; end
         4'h5: begin m_r[rd] = b;     c = 4; e = 1; end
         4'h6: begin m_r[rd] = imm; m_pc = pc1 + 8'd1; c = 4; e = 1; end
         4'h7: begin m_r[rd] = m_mem[b]; c = 5; e = 1; end
         4'h8: begin m_mem[b] = a; c = 4; m = 1; end
         4'h9: begin m_pc = (a == b) ? imm : pc1 + 8'd1; c = 4; end
         4'hA: begin m_pc = imm; c = 3; end
         default: il = 1;
      endcase
   endtask

   initial begin
      int n, en;
      int c, e, m, il, b, dc, de, dm, di;
      logic [7:0] ma, md;

      for (int i = 0; i < 256; i++) imem[i] = 8'h00;
      imem[8'h00] = 8'h64; imem[8'h01] = 8'h05;   // LI r1,05
      imem[8'h02] = 8'h68; imem[8'h03] = 8'h03;   // LI r2,03
      imem[8'h04] = 8'h16;                        // ADD r1,r2
      imem[8'h05] = 8'h60; imem[8'h06] = 8'hFF;   // LI r0,FF
      imem[8'h07] = 8'h64; imem[8'h08] = 8'h01;   // LI r1,01
      imem[8'h09] = 8'h11;                        // ADD r0,r1
      imem[8'h0A] = 8'h25;                        // SUB r1,r1
      imem[8'h0B] = 8'h6C; imem[8'h0C] = 8'h20;   // LI r3,20
      imem[8'h0D] = 8'h68; imem[8'h0E] = 8'hAA;   // LI r2,AA
      imem[8'h0F] = 8'h8B;                        // SW r2,[r3]
      imem[8'h10] = 8'h73;                        // LW r0,[r3]
      imem[8'h11] = 8'h90; imem[8'h12] = 8'h20;   // BEQ r0,r0,20
      imem[8'h20] = 8'h91; imem[8'h21] = 8'h55;   // BEQ r0,r1 (not taken)
      imem[8'h22] = 8'hC0;                        // illegal
      imem[8'h23] = 8'hA0; imem[8'h24] = 8'h30;   // JMP 30
      imem[8'h30] = 8'hF0;                        // HLT

      reset = 1'b1;
      fill_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         fill_addr = 8'(i); fill_val = 8'h00;
         @(posedge clk); #1;
      end
      fill_en = 1'b0;
      chk("rst_pc", imem_addr, 8'h00);
      chk("rst_estado", estado, 3'd0);
      chk("rst_escreg", EscReg, 1'b0);
      chk("rst_escmem", EscMem, 1'b0);
      chk("rst_parado", parado, 1'b0);
      chk("rst_ilegal", ilegal, 1'b0);
      reset = 1'b0;

      instr("li_r1", 4, 1, 0, 0, 8'h02);  chk("r1_05", bank[1], 8'h05);
      instr("li_r2", 4, 1, 0, 0, 8'h04);  chk("r2_03", bank[2], 8'h03);
      instr("add",   4, 1, 0, 0, 8'h05);  chk("r1_08", bank[1], 8'h08);
      instr("li_r0", 4, 1, 0, 0, 8'h07);
      instr("li_r1b",4, 1, 0, 0, 8'h09);
      instr("add_wrap", 4, 1, 0, 0, 8'h0A); chk("r0_wrap", bank[0], 8'h00);
      instr("sub",   4, 1, 0, 0, 8'h0B);  chk("r1_sub", bank[1], 8'h00);
      instr("li_r3", 4, 1, 0, 0, 8'h0D);
      instr("li_r2b",4, 1, 0, 0, 8'h0F);
      instr("sw",    4, 0, 1, 0, 8'h10);
      chk("sw_addr", last_ma, 8'h20);
      chk("sw_data", last_md, 8'hAA);
      chk("sw_mem", dmem[8'h20], 8'hAA);
      instr("lw",    5, 1, 0, 0, 8'h11);  chk("r0_lw", bank[0], 8'hAA);
      instr("beq_taken", 4, 0, 0, 0, 8'h20);
      instr("beq_not",   4, 0, 0, 0, 8'h22);
      instr("illegal",   2, 0, 0, 1, 8'h23);
      instr("jmp",       3, 0, 0, 0, 8'h30);

      repeat (2) begin @(posedge clk); #1; end
      chk("hlt_estado", estado, 3'd6);
      chk("hlt_parado", parado, 1'b1);
      en = 0;
      repeat (22) begin
         @(posedge clk); #1;
         if (EscReg || EscMem || estado != 3'd6) en++;
      end
      chk("hlt_quiet", en, 0);
      chk("hlt_pc", imem_addr, 8'h31);

      // reset during ESCR of ADD r1,r2
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
      instr("ra_li_r1", 4, 1, 0, 0, 8'h02);
      instr("ra_li_r2", 4, 1, 0, 0, 8'h04);
      n = 0;
      while (estado != 3'd5 && n < 8) begin @(posedge clk); #1; n++; end
      chk("ra_reach_escr", estado, 3'd5);
      chk("ra_escreg_on", EscReg, 1'b1);
      reset = 1'b1; #1;
      chk("ra_escreg_drop", EscReg, 1'b0);
      chk("ra_estado_async", estado, 3'd0);
      @(posedge clk); #1; @(posedge clk); #1;
      reset = 1'b0; #1;
      chk("ra_r1_kept", bank[1], 8'h05);
      chk("ra_pc", imem_addr, 8'h00);
      chk("ra_estado", estado, 3'd0);

      // random programs, opcode F excluded so the run never halts
      reset = 1'b1;
      for (int i = 0; i < 256; i++) imem[i] = 8'($urandom_range(0, 239));
      fill_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         fill_addr = 8'(i); fill_val = 8'($urandom);
         @(posedge clk); #1;
      end
      fill_en = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) m_mem[i] = dmem[i];
      for (int i = 0; i < 4; i++) m_r[i] = bank[i];
      m_pc = 8'h00;
      reset = 1'b0;

      for (int k = 0; k < 300; k++) begin
         model_step(dc, de, dm, di);
         exec_one(c, e, m, il, b, ma, md);
         chk("rnd_cycles", c, dc);
         chk("rnd_escreg", e, de);
         chk("rnd_escmem", m, dm);
         chk("rnd_ilegal", il, di);
         chk("rnd_stray_en", b, 0);
         chk("rnd_pc", imem_addr, m_pc);
         chk("rnd_regs", {bank[3], bank[2], bank[1], bank[0]},
             {m_r[3], m_r[2], m_r[1], m_r[0]});
      end
      for (int i = 0; i < 256; i++) chk("rnd_dmem", dmem[i], m_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
